fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the decoder. Holds the PC and issues
//  one read per cycle to a synchronous instruction memory (1-cycle read latency).
//  Delivers {instruction, pc} to the decoder over a valid/ready handshake through a
//  small output buffer. Accepts redirects from branch resolution and drops wrong-path work.
// PARAMETERS
//  PC_W       9       PC width, byte address; always word aligned (pc[1:0]==0)
//  INSTR_W    32      instruction width
//  RESET_PC   9'h000  PC fetched first after reset
//  BUF_DEPTH  2       output buffer entries (>=2)
// PORTS
//  clk            in   1        clock
//  reset          in   1        asynchronous reset, active-high
//  o_imem_en      out  1        read enable this cycle
//  o_imem_addr    out  PC_W-2   word address (= fetch pc[PC_W-1:2])
//  i_imem_rdata   in   INSTR_W  read data, valid the cycle after o_imem_en
//  i_redirect     in   1        1-cycle pulse: restart fetch at i_redirect_pc
//  i_redirect_pc  in   PC_W     redirect target, word aligned
//  o_instruction  out  INSTR_W  to decoder instruction
//  o_pc           out  PC_W     to decoder i_pc
//  o_valid        out  1        buffer head valid
//  i_ready        in   1        decoder accepts head
// BEHAVIOUR
//  - Reset (async assert): pc_q=RESET_PC, buffer count=0, rsp_v_q=0; o_valid=0,
//    o_imem_en=0, o_instruction=0, o_pc=0. Fetch begins on the first clk edge after release.
//  - pop = o_valid & i_ready. Head is removed on pop; o_instruction/o_pc are the head entry.
//  - issue = (count + rsp_v_q - pop) < BUF_DEPTH. Comb path i_ready->o_imem_en is allowed.
//    o_imem_en = issue. o_imem_addr = fetch_pc[PC_W-1:2],
//    where fetch_pc = i_redirect ? i_redirect_pc : pc_q.
//  - On issue: pc_q <= fetch_pc + 4, wrapping modulo 2^PC_W. Else pc_q <= fetch_pc.
//    A redirect with no issue therefore still loads pc_q.
//  - rsp_v_q <= issue; rsp_pc_q <= fetch_pc. When rsp_v_q=1, i_imem_rdata with tag
//    rsp_pc_q is pushed into the buffer tail in that cycle, unless i_redirect=1.
//  - Throughput: 1 instr/cycle with i_ready held high. First o_valid comes 2 cycles after
//    the first issue edge: issue at cycle 0, rdata at 1, valid at 2.
//  - The issue rule guarantees no overflow. Push and pop in the same cycle are both honoured
//    (count unchanged). Push when empty is visible the next cycle.
//  - Redirect (cycle t): buffer flushed (count<=0); any response arriving in t is discarded;
//    o_valid forced 0 in t, so no pop occurs; issue at i_redirect_pc in t if issue=1.
//    The first output after a redirect is i_redirect_pc, with no stale-path entries.
//  - Redirect and reset together: reset wins.
//  - Reset mid-stream: all state cleared asynchronously; no partial entry survives;
//    fetch restarts at RESET_PC.
//  - Buffer is a circular FIFO; pointers wrap at BUF_DEPTH; count in [0,BUF_DEPTH].
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs o_perf_fetched[31:0] (pops) and
//    o_perf_stall[31:0] (cycles with o_valid & !i_ready).
//    Both are 0 on reset, saturate at 32'hFFFF_FFFF and are not cleared by redirect.
//  FETCH_PERF_EN undefined: these ports and counters do not exist; all other behaviour
//    is identical.
// TESTING
//  1 Reset release, i_ready=1, imem[w]=w -> o_pc 0x000,0x004,0x008... one per cycle;
//    first o_valid on the 2nd edge after release; o_instruction = o_pc>>2.
//  2 i_ready=0 for 10 cycles -> count reaches 2; o_imem_en=0 once full; on release the
//    sequence continues with no gap, duplicate or loss.
//  3 Buffer full of 0x010/0x014, i_redirect=1 with i_redirect_pc=0x100 -> o_valid=0 that
//    cycle; next outputs 0x100,0x104; 0x010/0x014 and in-flight data never appear.
//  4 Redirect to 0x1F8 -> outputs 0x1F8,0x1FC,0x000,0x004 (PC wrap).
//  5 reset asserted mid-stream with buffer half full -> o_valid=0 immediately (async);
//    after release the first output is 0x000.
//  6 FETCH_PERF_EN: 5 pops plus 3 stalled cycles -> o_perf_fetched=5, o_perf_stall=3;
//    both 0 after reset.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Holds the fetch PC and issues at most one read per cycle to a synchronous
// instruction memory (1-cycle latency). Returned words are tagged with their
// PC and queued in a small circular output buffer that the decoder drains
// over a valid/ready handshake. A redirect flushes the buffer, discards any
// response arriving in the same cycle and restarts fetch at the new target.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   o_imem_en / o_imem_addr    memory read request (word address)
//   i_imem_rdata               read data, valid the cycle after o_imem_en
//   i_redirect / i_redirect_pc 1-cycle restart request and its target
//   o_instruction / o_pc       buffer head towards the decoder
//   o_valid / i_ready          decoder handshake (pop = o_valid & i_ready)
//
// Optional feature (macro FETCH_PERF_EN):
//   o_perf_fetched  saturating count of pops
//   o_perf_stall    saturating count of cycles with o_valid & !i_ready
module fetch_unit #(
   parameter int unsigned     PC_W      = 9,
   parameter int unsigned     INSTR_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               o_imem_en,
   output logic [PC_W-3:0]    o_imem_addr,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   input  logic               i_redirect,
   input  logic [PC_W-1:0]    i_redirect_pc,
   output logic [INSTR_W-1:0] o_instruction,
   output logic [PC_W-1:0]    o_pc,
   output logic               o_valid,
   input  logic               i_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        o_perf_fetched,
   output logic [31:0]        o_perf_stall
`endif
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               rsp_v_q;
   logic [PC_W-1:0]    rsp_pc_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [INSTR_W-1:0] buf_instr_q [BUF_DEPTH];
   logic [PC_W-1:0]    buf_pc_q    [BUF_DEPTH];

   logic [PC_W-1:0]    fetch_pc;
   logic               pop;
   logic               push;
   logic               issue;
   logic [CNT_W:0]     occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      fetch_pc = i_redirect ? i_redirect_pc : pc_q;
      // A redirect hides the head so the decoder never consumes wrong-path work.
      o_valid  = (count_q != '0) && !i_redirect;
      pop      = o_valid && i_ready;
      push     = rsp_v_q && !i_redirect;
      // Occupancy once this cycle's pop and the in-flight response settle;
      // issuing only while it is below depth guarantees the buffer never overflows.
      occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, rsp_v_q} - {{CNT_W{1'b0}}, pop};
      issue    = !reset && (occ < (CNT_W + 1)'(BUF_DEPTH));
      pc_d     = issue ? fetch_pc + PC_W'(4) : fetch_pc;

      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (i_redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      end
   end

   assign o_imem_en     = issue;
   assign o_imem_addr   = fetch_pc[PC_W-1:2];
   assign o_instruction = buf_instr_q[rd_ptr_q];
   assign o_pc          = buf_pc_q[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         rsp_v_q  <= 1'b0;
         rsp_pc_q <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc_q[i]    <= '0;
         end
      end else begin
         pc_q     <= pc_d;
         rsp_v_q  <= issue;
         rsp_pc_q <= fetch_pc;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) begin
            buf_instr_q[wr_ptr_q] <= i_imem_rdata;
            buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   // Counters survive redirects; only reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (pop && (perf_fetched_q != '1))
            perf_fetched_q <= perf_fetched_q + 32'd1;
         if (o_valid && !i_ready && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign o_perf_fetched = perf_fetched_q;
   assign o_perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed per-cycle vector table plus hand-written
// sequences for asynchronous reset and the optional performance counters.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        o_imem_en;
   logic [6:0]  o_imem_addr;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [8:0]  i_redirect_pc;
   logic [31:0] o_instruction;
   logic [8:0]  o_pc;
   logic        o_valid;
   logic        i_ready;
`ifdef FETCH_PERF_EN
   logic [31:0] o_perf_fetched;
   logic [31:0] o_perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit #(
      .PC_W      (9),
      .INSTR_W   (32),
      .RESET_PC  (9'h000),
      .BUF_DEPTH (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .o_imem_en     (o_imem_en),
      .o_imem_addr   (o_imem_addr),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_instruction (o_instruction),
      .o_pc          (o_pc),
      .o_valid       (o_valid),
      .i_ready       (i_ready)
`ifdef FETCH_PERF_EN
      ,
      .o_perf_fetched(o_perf_fetched),
      .o_perf_stall  (o_perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: word w holds 32'hC0DE_0000 | w.
   always @(posedge clk) begin
      if (o_imem_en) i_imem_rdata <= {16'hC0DE, 9'b0, o_imem_addr};
   end

   function automatic logic [31:0] word_of(input logic [8:0] pc);
      return {16'hC0DE, 9'b0, pc[8:2]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       ready;
      logic       redir;
      logic [8:0] rpc;
      logic       ev;
      logic [8:0] epc;
      logic       een;
      logic [8:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic rd, input logic [8:0] rp,
                      input logic ev, input logic [8:0] epc,
                      input logic een, input logic [8:0] ea);
      vec_t v;
      v.ready = r; v.redir = rd; v.rpc = rp;
      v.ev = ev; v.epc = epc; v.een = een; v.eaddr = ea;
      vecs.push_back(v);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " valid"}, 32'(o_valid), 32'd0);
      check({tag, " en"},    32'(o_imem_en), 32'd0);
      check({tag, " pc"},    32'(o_pc), 32'd0);
      check({tag, " instr"}, o_instruction, 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      i_ready       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      i_imem_rdata  = '0;

      // Stream from reset, then stall, then flush of a full buffer.
      add(1,0,9'h000, 0,9'h000, 1,9'h000);
      add(1,0,9'h000, 0,9'h000, 1,9'h004);
      add(1,0,9'h000, 1,9'h000, 1,9'h008);
      add(1,0,9'h000, 1,9'h004, 1,9'h00C);
      add(1,0,9'h000, 1,9'h008, 1,9'h010);
      for (int k = 0; k < 10; k++) add(0,0,9'h000, 1,9'h00C, 0,9'h000);
      add(1,0,9'h000, 1,9'h00C, 1,9'h014);
      add(0,0,9'h000, 1,9'h010, 0,9'h000);
      add(1,1,9'h100, 0,9'h000, 0,9'h000);
      add(1,0,9'h000, 0,9'h000, 1,9'h100);
      add(1,0,9'h000, 0,9'h000, 1,9'h104);
      add(1,0,9'h000, 1,9'h100, 1,9'h108);
      add(1,0,9'h000, 1,9'h104, 1,9'h10C);
      // Redirect with a response in flight, then PC wrap.
      add(1,1,9'h1F8, 0,9'h000, 0,9'h000);
      add(1,0,9'h000, 0,9'h000, 1,9'h1F8);
      add(1,0,9'h000, 0,9'h000, 1,9'h1FC);
      add(1,0,9'h000, 1,9'h1F8, 1,9'h000);
      add(1,0,9'h000, 1,9'h1FC, 1,9'h004);
      add(1,0,9'h000, 1,9'h000, 1,9'h008);
      add(1,0,9'h000, 1,9'h004, 1,9'h00C);
      // Back-to-back redirects: the second one issues at its own target.
      add(1,1,9'h040, 0,9'h000, 0,9'h000);
      add(1,1,9'h080, 0,9'h000, 1,9'h080);
      add(1,0,9'h000, 0,9'h000, 1,9'h084);
      add(1,0,9'h000, 1,9'h080, 1,9'h088);

      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_state("reset");

      @(posedge clk);
      #1 reset = 1'b0;
      foreach (vecs[i]) begin
         if (i != 0) begin
            @(posedge clk);
            #1;
         end
         i_ready       = vecs[i].ready;
         i_redirect    = vecs[i].redir;
         i_redirect_pc = vecs[i].rpc;
         #3;
         check($sformatf("row%0d valid", i), 32'(o_valid), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            check($sformatf("row%0d pc", i), 32'(o_pc), 32'(vecs[i].epc));
            check($sformatf("row%0d instr", i), o_instruction, word_of(vecs[i].epc));
         end
         check($sformatf("row%0d en", i), 32'(o_imem_en), 32'(vecs[i].een));
         if (vecs[i].een)
            check($sformatf("row%0d addr", i), 32'(o_imem_addr), 32'(vecs[i].eaddr[8:2]));
      end

      // Mid-stream asynchronous reset with one entry buffered, redirect held alongside.
      @(posedge clk);
      #1;
      i_ready    = 1'b0;
      i_redirect = 1'b0;
      #2;
      check("pre-reset valid", 32'(o_valid), 32'd1);
      check("pre-reset pc", 32'(o_pc), 32'h084);
      reset         = 1'b1;
      i_redirect    = 1'b1;
      i_redirect_pc = 9'h100;
      #1;
      check_reset_state("async reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_state("held reset");
      @(posedge clk);
      #1;
      reset      = 1'b0;
      i_redirect = 1'b0;
      i_ready    = 1'b1;
      #3;
      check("restart c0 en", 32'(o_imem_en), 32'd1);
      check("restart c0 addr", 32'(o_imem_addr), 32'd0);
      check("restart c0 valid", 32'(o_valid), 32'd0);
      @(posedge clk);
      #4;
      check("restart c1 valid", 32'(o_valid), 32'd0);
      @(posedge clk);
      #4;
      check("restart c2 valid", 32'(o_valid), 32'd1);
      check("restart c2 pc", 32'(o_pc), 32'h000);
      check("restart c2 instr", o_instruction, word_of(9'h000));
      @(posedge clk);
      #4;
      check("restart c3 pc", 32'(o_pc), 32'h004);

`ifdef FETCH_PERF_EN
      // Three stalled cycles followed by five pops.
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      i_ready = 1'b0;
      #3;
      check("perf fetched after reset", o_perf_fetched, 32'd0);
      check("perf stall after reset", o_perf_stall, 32'd0);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         i_ready = (c >= 5 && c <= 9);
      end
      #3;
      check("perf fetched", o_perf_fetched, 32'd5);
      check("perf stall", o_perf_stall, 32'd3);
      reset = 1'b1;
      #1;
      check("perf fetched cleared", o_perf_fetched, 32'd0);
      check("perf stall cleared", o_perf_stall, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
